seg_scan_ctrl: RTL

//   Upstream feeder for the 8-digit seven-segment decoder (num/sel -> segments/anode).
//   - Holds an 8 x 4-bit digit buffer.
//   - Time-multiplexes the buffer onto num[3:0]/sel[2:0], advancing one digit per refresh

---
 rtl/seg_scan_ctrl_pkg.sv | 14 +
 rtl/seg_scan_ctrl_if.sv | 27 ++
 rtl/seg_scan_ctrl_prescaler.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 62 ++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and sizes for the seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SEL_W-1:0]   sel_t;

    // Packed so that digit i occupies bits [4i+3:4i] of a flat 32-bit load word.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_buf_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side write/load/mask signals and decoder-side scan outputs.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic                          wr_en;
    sel_t                          wr_addr;
    digit_t                        wr_data;
    logic                          load_en;
    logic [NUM_DIGITS*DIGIT_W-1:0] load_data;
    logic [NUM_DIGITS-1:0]         digit_en;

    digit_t                        num;
    sel_t                          sel;
    logic                          blank;
    logic                          scan_tick;

    modport master (
        output wr_en, wr_addr, wr_data, load_en, load_data, digit_en,
        input  num, sel, blank, scan_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, load_en, load_data, digit_en,
        output num, sel, blank, scan_tick
    );

endinterface

// File: rtl/seg_scan_ctrl_prescaler.sv
// Refresh prescaler: one-cycle tick every DIV clocks.
// Implemented as a down-counter that reloads DIV-1 and ticks at zero, so the
// tick lands on the DIV-th cycle after reset exactly as an up-count would.
module seg_prescaler #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned    CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == '0);

    // Terminal count reloads; otherwise keep counting down.
    always_comb begin
        cnt_d = tick_o ? RELOAD : cnt_q - CNT_W'(1);
    end

    // Counter register; reset restarts a full slot.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= RELOAD;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit scan controller: holds the digit buffer and time-multiplexes it
// onto num/sel for the seven-segment decoder, one digit per refresh slot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_ctrl_if.slave bus
);

    logic       tick;
    digit_buf_t dbuf_q, dbuf_d;
    sel_t       sel_q, sel_next;
    digit_t     num_q, num_d;
    logic       blank_q, blank_d;
    logic       scan_tick_q;

    seg_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // Buffer update: a full load wins over a single-digit write.
    always_comb begin
        dbuf_d = dbuf_q;
        if (bus.load_en)    dbuf_d = bus.load_data;
        else if (bus.wr_en) dbuf_d[bus.wr_addr] = bus.wr_data;
    end

    // Next digit and its outputs; reading dbuf_d gives write-through on the same edge.
    always_comb begin
        sel_next = tick ? sel_t'(sel_q + sel_t'(1)) : sel_q;
        num_d    = dbuf_d[sel_next];
        blank_d  = ~bus.digit_en[sel_next];
    end

    // All outputs registered together so num, sel and blank switch on one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbuf_q      <= '0;
            sel_q       <= '0;
            num_q       <= '0;
            blank_q     <= 1'b0;
            scan_tick_q <= 1'b0;
        end else begin
            dbuf_q      <= dbuf_d;
            sel_q       <= sel_next;
            num_q       <= num_d;
            blank_q     <= blank_d;
            scan_tick_q <= tick;
        end
    end

    assign bus.num       = num_q;
    assign bus.sel       = sel_q;
    assign bus.blank     = blank_q;
    assign bus.scan_tick = scan_tick_q;

endmodule
